// File: rtl/luks_sample_ctrl.sv
// Sample scheduler for the SPI light-sensor reader: periodic conversion requests,
// DEPTH-entry circular sample buffer and a moving average over the last DEPTH samples.
module luks_sample_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int DEPTH         = 8,
  parameter int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          clr,
  output logic          valid,
  input  logic          ready,
  input  logic [7:0]    toMemory,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          sample_stb,
  output logic [AW:0]   count,
  output logic [7:0]    avg,
  output logic          avg_valid,
  output logic          overrun
);

  localparam int            CW       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] PER_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam int            SW       = AW + 8;

  typedef enum logic [1:0] {IDLE, WAIT, REQ, STORE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] per_cnt;
  logic          tick;
  logic          ready_q;
  logic          ready_rise;
  logic          capture;
  logic          store;
  logic          full;
  logic [7:0]    sample_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_phys;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_nxt;
  logic [7:0]    mem [DEPTH];

  function automatic logic [AW:0] sat_inc(input logic [AW:0] c);
    return (c == FULL_CNT) ? c : c + (AW+1)'(1);
  endfunction

  // Average is a plain truncating shift; it reads as zero until the window is full.
  function automatic logic [7:0] trunc_avg(input logic [SW-1:0] s, input logic f);
    logic [SW-1:0] sh;
    sh = s >> AW;
    return f ? sh[7:0] : 8'd0;
  endfunction

  assign tick       = (per_cnt == PER_LAST);
  assign ready_rise = ready & ~ready_q;
  assign store      = (state == STORE);
  assign full       = (count == FULL_CNT);
  assign rd_phys    = (full ? wr_ptr : '0) + rd_addr;
  assign sum_nxt    = sum + SW'(sample_q) - (full ? SW'(mem[wr_ptr]) : '0);
  assign avg        = trunc_avg(sum, full);
  assign avg_valid  = full;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable)   state_nxt = IDLE;
        else if (tick) state_nxt = REQ;
      end
      REQ: begin
        if (ready_rise) begin
          capture   = 1'b1;
          state_nxt = STORE;
        end
      end
      STORE:   state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: FSM, registered request line, period counter, commit strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      valid      <= 1'b0;
      ready_q    <= 1'b0;
      per_cnt    <= '0;
      sample_stb <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid      <= (state_nxt == REQ);
      ready_q    <= ready;
      sample_stb <= store;
      if (!enable || tick) per_cnt <= '0;
      else                 per_cnt <= per_cnt + CW'(1);
    end
  end

  // Buffer bookkeeping; clr wins over a commit in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count   <= '0;
      wr_ptr  <= '0;
      sum     <= '0;
      overrun <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      rd_data <= mem[rd_phys];
      if (clr) begin
        count   <= '0;
        wr_ptr  <= '0;
        sum     <= '0;
        overrun <= 1'b0;
      end else begin
        if (store) begin
          sum    <= sum_nxt;
          wr_ptr <= wr_ptr + AW'(1);
          count  <= sat_inc(count);
        end
        if (tick && (state == REQ || state == STORE)) overrun <= 1'b1;
      end
    end
  end

  // Sample capture and buffer storage.
  always_ff @(posedge clk) begin
    if (capture) sample_q <= toMemory;
    if (store && !clr) mem[wr_ptr] <= sample_q;
  end

endmodule

// File: tb/tb_luks_sample_ctrl.sv
// Bench for luks_sample_ctrl: directed vector table, multi-cycle corner sequences
// and randomized samples against a queue-based moving-average model.
`timescale 1ns/1ps
module tb_luks_sample_ctrl;
  localparam int P  = 16;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          clr;
  logic          ready;
  logic [7:0]    to_mem;
  logic [AW-1:0] rd_addr;
  logic          valid;
  logic [7:0]    rd_data;
  logic          sample_stb;
  logic [AW:0]   count;
  logic [7:0]    avg;
  logic          avg_valid;
  logic          overrun;

  int nvec = 0;
  int nerr = 0;
  byte unsigned q[$];
  bit exp_ovr = 1'b0;

  typedef struct {
    byte unsigned data;
    int           dly;
    int           exp_count;
    int           exp_avg;
    bit           exp_av;
  } vec_t;

  always #5 clk = ~clk;

  luks_sample_ctrl #(.SAMPLE_PERIOD(P), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clr(clr), .valid(valid),
    .ready(ready), .toMemory(to_mem), .rd_addr(rd_addr), .rd_data(rd_data),
    .sample_stb(sample_stb), .count(count), .avg(avg), .avg_valid(avg_valid),
    .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the window is simply the last D committed samples.
  function automatic void m_push(input byte unsigned b);
    q.push_back(b);
    if (q.size() > D) void'(q.pop_front());
  endfunction

  function automatic int m_avg();
    int s = 0;
    if (q.size() != D) return 0;
    foreach (q[i]) s += q[i];
    return s / D;
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4*P; i++) begin
      if (valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Reader model: answer the pending request after dly cycles.
  task automatic serve(input byte unsigned data, input int dly, input bit hold,
                       input bit clr_st, output bit got);
    bit ok;
    got = 1'b0;
    wait_valid(ok);
    check("valid_seen", ok, 1);
    if (!ok) return;
    repeat (dly) @(negedge clk);
    ready  = 1'b1;
    to_mem = data;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= int'(hold)) ready = 1'b0;
      clr = clr_st && (i == 0);
      if (i == 0) check("valid_drop", valid, 0);
      if (sample_stb) begin
        got = 1'b1;
        break;
      end
    end
    ready = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic commit(input byte unsigned data, input int dly, input bit hold,
                        input bit clr_st);
    bit got;
    serve(data, dly, hold, clr_st, got);
    check("sample_stb", got, 1);
    if (clr_st) q.delete();
    else        m_push(data);
    check("count", count, q.size());
    check("avg", avg, m_avg());
    check("avg_valid", avg_valid, q.size() == D);
    check("overrun", overrun, exp_ovr);
  endtask

  task automatic readback(input int addr, input int exp);
    rd_addr = AW'(addr);
    @(negedge clk);
    check("rd_data", rd_data, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    byte unsigned rb_exp[4];
    bit ok;
    bit seen;
    int first;

    tbl[0] = '{8'h0A, 2, 1, 0,     1'b0};
    tbl[1] = '{8'h14, 0, 2, 0,     1'b0};
    tbl[2] = '{8'h1E, 5, 3, 0,     1'b0};
    tbl[3] = '{8'h28, 1, 4, 8'h19, 1'b1};
    tbl[4] = '{8'h64, 3, 4, 8'h2F, 1'b1};
    rb_exp = '{8'h14, 8'h1E, 8'h28, 8'h64};

    rstn = 1'b0; enable = 1'b1; clr = 1'b0; ready = 1'b0; to_mem = 8'h00; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_sample_stb", sample_stb, 0);
    check("rst_count", count, 0);
    check("rst_avg", avg, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_data", rd_data, 0);

    rstn  = 1'b1;
    first = -1;
    for (int n = 1; n <= 3*P; n++) begin
      @(negedge clk);
      if (valid) begin
        first = n;
        break;
      end
    end
    check("first_valid_cycle", first, P);

    for (int i = 0; i < 5; i++) begin
      serve(tbl[i].data, tbl[i].dly, 1'b0, 1'b0, ok);
      check("tbl_stb", ok, 1);
      check("tbl_count", count, tbl[i].exp_count);
      check("tbl_avg", avg, tbl[i].exp_avg);
      check("tbl_avg_valid", avg_valid, tbl[i].exp_av);
      m_push(tbl[i].data);
    end
    for (int i = 0; i < 4; i++) readback(i, rb_exp[i]);

    // A ready level already high when the request appears is not a new edge.
    commit(8'h33, 0, 1'b0, 1'b0);
    ready  = 1'b1;
    to_mem = 8'h77;
    wait_valid(ok);
    check("level_valid_seen", ok, 1);
    repeat (3) @(negedge clk);
    check("valid_held_level_ready", valid, 1);
    check("no_capture_on_level", sample_stb, 0);
    ready = 1'b0;
    @(negedge clk);
    commit(8'h55, 0, 1'b0, 1'b0);

    // Slow reader: a tick lands while the request is outstanding.
    wait_valid(ok);
    check("ovr_valid_seen", ok, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid) seen = 1'b1;
    end
    check("valid_held_no_dup", seen, 0);
    check("overrun_set", overrun, 1);
    exp_ovr = 1'b1;
    commit(8'h3C, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("overrun_sticky", overrun, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    q.delete();
    exp_ovr = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_count", count, 0);
    check("clr_avg", avg, 0);
    check("clr_avg_valid", avg_valid, 0);

    // Enable dropped mid-request: request completes, then no further requests.
    wait_valid(ok);
    check("en_valid_seen", ok, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("valid_held_disabled", valid, 1);
    commit(8'h42, 0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3*P; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check("no_valid_when_disabled", seen, 0);
    enable = 1'b1;

    // clr on the commit cycle discards the sample.
    commit(8'hA5, 1, 1'b0, 1'b1);
    commit(8'hC3, 2, 1'b0, 1'b0);
    readback(0, 8'hC3);

    for (int it = 0; it < 40; it++) begin
      int a;
      commit(byte'($urandom_range(0, 255)), $urandom_range(0, 8),
             bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if (q.size() > 0) begin
        a = $urandom_range(0, q.size() - 1);
        readback(a, q[a]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
